// File: rtl/sram_array.sv
// 1R1W word-addressed memory tiled from 8x1024 sky130 macros, with byte enables,
// read-data hold, same-cycle write->read forwarding and a whole-array clear engine.

// Behavioural stand-in for the sky130 1r1w 8x1024 macro (port 0 write, port 1 read).
module sky130_sram_1kbyte_1r1w_8x1024_8 (
    input  logic       clk0,
    input  logic       csb0,
    input  logic       web0,
    input  logic [9:0] addr0,
    input  logic [7:0] din0,
    input  logic       clk1,
    input  logic       csb1,
    input  logic [9:0] addr1,
    output logic [7:0] dout1
);
    logic [7:0] mem_r [1024];

    // Write port
    always_ff @(posedge clk0) begin
        if (!csb0 && !web0) begin
            mem_r[addr0] <= din0;
        end
    end

    // Read port; output holds while deselected
    always_ff @(posedge clk1) begin
        if (!csb1) begin
            dout1 <= mem_r[addr1];
        end
    end
endmodule

module sram_array #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4096,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wr_en,
    input  logic [ADDR_W-1:0]    wr_addr,
    input  logic [DATA_W/8-1:0]  wr_be,
    input  logic [DATA_W-1:0]    wr_data,
    input  logic                 rd_en,
    input  logic [ADDR_W-1:0]    rd_addr,
    output logic [DATA_W-1:0]    rd_data,
    output logic                 rd_valid,
    input  logic                 clr,
    output logic                 busy
);
    localparam int LANES  = DATA_W / 8;
    localparam int BANKS  = DEPTH / 1024;
    localparam int BANK_W = (BANKS > 1) ? $clog2(BANKS) : 1;
    localparam int NMAC   = BANKS * LANES;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t                      state_r, state_s;
    logic [9:0]                  row_r, row_s;
    logic                        clearing_s, user_wr_s, user_rd_s, collide_s;
    logic [BANK_W-1:0]           wr_bank_s, rd_bank_s, rd_bank_r;
    logic [NMAC-1:0]             csb0_s, csb1_s;
    logic [9:0]                  addr0_s;
    logic [DATA_W-1:0]           din_s;
    logic [BANKS-1:0][DATA_W-1:0] dout_s;
    logic [DATA_W-1:0]           bank_word_s, rd_word_s, hold_r, fwd_data_r;
    logic [LANES-1:0]            fwd_be_r;
    logic                        rd_valid_r;

    assign wr_bank_s  = BANK_W'(wr_addr >> 10);
    assign rd_bank_s  = BANK_W'(rd_addr >> 10);
    assign clearing_s = (state_r == CLEAR);
    // A clr request in IDLE takes priority over user traffic in the same cycle
    assign user_wr_s  = rst_n && !clearing_s && !clr && wr_en;
    assign user_rd_s  = rst_n && !clearing_s && !clr && rd_en;
    assign collide_s  = user_wr_s && user_rd_s && (wr_addr == rd_addr);

    // Clear FSM state and row counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
            row_r   <= 10'd0;
        end else begin
            state_r <= state_s;
            row_r   <= row_s;
        end
    end

    // Clear FSM next state
    always_comb begin
        state_s = state_r;
        row_s   = row_r;
        case (state_r)
            IDLE: begin
                if (clr) begin
                    state_s = CLEAR;
                    row_s   = 10'd0;
                end else begin
                    state_s = IDLE;
                    row_s   = 10'd0;
                end
            end
            CLEAR: begin
                if (row_r == 10'd1023) begin
                    state_s = IDLE;
                    row_s   = 10'd0;
                end else begin
                    state_s = CLEAR;
                    row_s   = row_r + 10'd1;
                end
            end
            default: begin
                state_s = IDLE;
                row_s   = 10'd0;
            end
        endcase
    end

    // Macro chip-select and write-port decode; only addressed lanes are enabled
    always_comb begin
        csb0_s  = {NMAC{1'b1}};
        csb1_s  = {NMAC{1'b1}};
        addr0_s = wr_addr[9:0];
        din_s   = wr_data;
        if (!rst_n) begin
            csb0_s = {NMAC{1'b1}};
            csb1_s = {NMAC{1'b1}};
        end else if (clearing_s) begin
            csb0_s  = {NMAC{1'b0}};
            addr0_s = row_r;
            din_s   = {DATA_W{1'b0}};
        end else begin
            for (int b = 0; b < BANKS; b++) begin
                for (int l = 0; l < LANES; l++) begin
                    csb0_s[b*LANES+l] = !(user_wr_s && wr_be[l] && (wr_bank_s == BANK_W'(b)));
                    csb1_s[b*LANES+l] = !(user_rd_s && (rd_bank_s == BANK_W'(b)));
                end
            end
        end
    end

    for (genvar b = 0; b < BANKS; b++) begin : g_bank
        for (genvar l = 0; l < LANES; l++) begin : g_lane
            sky130_sram_1kbyte_1r1w_8x1024_8 u_macro (
                .clk0  (clk),
                .csb0  (csb0_s[b*LANES+l]),
                .web0  (1'b0),
                .addr0 (addr0_s),
                .din0  (din_s[8*l +: 8]),
                .clk1  (clk),
                .csb1  (csb1_s[b*LANES+l]),
                .addr1 (rd_addr[9:0]),
                .dout1 (dout_s[b][8*l +: 8])
            );
        end
    end

    // Read-side pipeline: bank select, collision bypass lanes and held data
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_valid_r <= 1'b0;
            rd_bank_r  <= {BANK_W{1'b0}};
            fwd_be_r   <= {LANES{1'b0}};
            fwd_data_r <= {DATA_W{1'b0}};
            hold_r     <= {DATA_W{1'b0}};
        end else begin
            rd_valid_r <= user_rd_s;
            if (user_rd_s) begin
                rd_bank_r  <= rd_bank_s;
                fwd_be_r   <= collide_s ? wr_be : {LANES{1'b0}};
                fwd_data_r <= wr_data;
            end
            if (rd_valid_r) begin
                hold_r <= rd_word_s;
            end
        end
    end

    // Written lanes of a colliding read come from the captured write data
    always_comb begin
        bank_word_s = dout_s[rd_bank_r];
        rd_word_s   = bank_word_s;
        for (int l = 0; l < LANES; l++) begin
            rd_word_s[8*l +: 8] = fwd_be_r[l] ? fwd_data_r[8*l +: 8] : bank_word_s[8*l +: 8];
        end
    end

    assign rd_data  = rd_valid_r ? rd_word_s : hold_r;
    assign rd_valid = rd_valid_r;
    assign busy     = clearing_s;
endmodule
